// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Load/store controller between the MEM stage and a word-only data memory.
//   The memory has a combinational word read and a clocked full-word write,
//   so byte and halfword stores become read-modify-write sequences. A halfword
//   at byte offset 3 spans two words and needs two reads and two writes.
//   Load data is extracted, then sign- or zero-extended.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   req_valid      request present          req_ready   accept possible (IDLE only)
//   req_we         1 = store, 0 = load      req_funct3  RISC-V funct3
//   req_addr       byte address             req_wdata   store data
//   resp_valid     one-cycle completion pulse
//   resp_rdata     extended load data (0 for stores and errors), held until next response
//   resp_err       misaligned word or illegal funct3, valid with resp_valid
//   mem_we         word write enable        mem_addr    word-aligned address
//   mem_wd         word write data          mem_rd      combinational read data
module dmem_access_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  localparam int SHW = $clog2(2*XLEN);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  state_t          state, state_nx;
  logic            op_we, op_err;
  logic [2:0]      op_f3;
  logic [XLEN-1:0] op_addr, op_wdata;
  logic [XLEN-1:0] buf0, buf1, rdata_q;

  logic            accept, req_bad, split;
  logic [1:0]      k;
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] word0, word1;
  logic [XLEN-1:0] merge0, merge1, rdata_nx;
  logic            ld_b0, ld_b1, ld_rd, we_c;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Illegal funct3 encodings, or a word access that is not word aligned.
  assign req_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  assign k     = op_addr[1:0];
  assign sh    = SHW'({k, 3'b000});
  assign split = (op_f3[1:0] == 2'b01) && (k == 2'b11);
  assign word0 = {op_addr[XLEN-1:2], 2'b00};
  assign word1 = word0 + XLEN'(4);  // wraps modulo 2^XLEN

  // Treat the two buffered words as one little-endian 2*XLEN field so the
  // offset-3 halfword needs no special case: it is simply bits [sh+15:sh].
  function automatic logic [XLEN-1:0] extract(input logic [2:0]      f3,
                                               input logic [SHW-1:0]  s,
                                               input logic [XLEN-1:0] b0,
                                               input logic [XLEN-1:0] b1);
    logic [2*XLEN-1:0] pair;
    logic [7:0]        by;
    logic [15:0]       hw;
    pair = {b1, b0};
    by   = pair[s +: 8];
    hw   = pair[s +: 16];
    case (f3)
      3'b000:  extract = {{(XLEN-8){by[7]}}, by};
      3'b001:  extract = {{(XLEN-16){hw[15]}}, hw};
      3'b010:  extract = b0;
      3'b100:  extract = {{(XLEN-8){1'b0}}, by};
      3'b101:  extract = {{(XLEN-16){1'b0}}, hw};
      default: extract = '0;
    endcase
  endfunction

  // Store merge over the same two-word field; merge1 only matters for split SH.
  always_comb begin
    logic [2*XLEN-1:0] pair;
    pair = {buf1, buf0};
    case (op_f3[1:0])
      2'b00:   pair[sh +: 8]     = op_wdata[7:0];
      2'b01:   pair[sh +: 16]    = op_wdata[15:0];
      2'b10:   pair[XLEN-1:0]    = op_wdata;
      default: pair              = {buf1, buf0};
    endcase
    merge0 = pair[XLEN-1:0];
    merge1 = pair[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nx = state;
    we_c     = 1'b0;
    mem_addr = word0;
    mem_wd   = '0;
    ld_b0    = 1'b0;
    ld_b1    = 1'b0;
    rdata_nx = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                                 state_nx = RESP;
          else if (req_we && req_funct3[1:0] == 2'b10) state_nx = WR0;
          else                                         state_nx = RD0;
        end
      end
      RD0: begin
        ld_b0 = 1'b1;
        if (split)      state_nx = RD1;
        else if (op_we) state_nx = WR0;
        else begin
          state_nx = RESP;
          // buf0 is still being loaded this cycle, so extract from mem_rd.
          rdata_nx = extract(op_f3, sh, mem_rd, buf1);
        end
      end
      RD1: begin
        mem_addr = word1;
        ld_b1    = 1'b1;
        if (op_we) state_nx = WR0;
        else begin
          state_nx = RESP;
          rdata_nx = extract(op_f3, sh, buf0, mem_rd);
        end
      end
      WR0: begin
        we_c     = 1'b1;
        mem_wd   = merge0;
        state_nx = split ? WR1 : RESP;
      end
      WR1: begin
        we_c     = 1'b1;
        mem_addr = word1;
        mem_wd   = merge1;
        state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Response data is captured on entry to RESP; stores and errors load 0.
    ld_rd = (state_nx == RESP) && (state != RESP);
  end

  // A reset arriving mid-access must not let a pending write through.
  assign mem_we     = we_c && !reset;
  assign resp_valid = (state == RESP) && !reset;
  assign resp_err   = resp_valid && op_err;
  assign resp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_we    <= 1'b0;
      op_err   <= 1'b0;
      op_f3    <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      buf0     <= '0;
      buf1     <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_we    <= req_we;
        op_err   <= req_bad;
        op_f3    <= req_funct3;
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
      end
      if (ld_b0) buf0    <= mem_rd;
      if (ld_b1) buf1    <= mem_rd;
      if (ld_rd) rdata_q <= rdata_nx;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a small word memory model sits on the
// memory port; expected writes and responses are queued when each request is
// driven and checked by a monitor when the DUT produces them.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  dmem_access_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // 16-word memory; the used addresses 0x0,0x100,0x200,0x300,0x304,0xFFFFFFFC
  // map to distinct entries through addr[9:8],addr[3:2].
  logic [31:0] mem [16];
  logic [3:0]  midx;
  assign midx   = {mem_addr[9:8], mem_addr[3:2]};
  assign mem_rd = mem[midx];
  always @(posedge clk) if (mem_we) mem[midx] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] rd; logic [31:0] err; int lat; int t; } rsp_t;
  wr_t  wq[$];
  rsp_t rq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: every write and response must match the head of its queue.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      chk("write_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w.a);
        chk("wr_data", mem_wd, w.d);
      end
    end
    if (resp_valid) begin
      chk("resp_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        rsp_t r;
        r = rq.pop_front();
        chk("rdata", resp_rdata, r.rd);
        chk("err", 32'(resp_err), r.err);
        chk("latency", 32'(cyc - r.t), 32'(r.lat));
      end
    end
  end

  task automatic expw(input logic [31:0] a, input logic [31:0] d);
    wq.push_back('{a, d});
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input logic err, input int lat);
    int n;
    @(negedge clk);
    chk("ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rq.push_back('{rd, 32'(err), lat, cyc});
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("timeout_pending", 32'(rq.size() + wq.size()), 32'd0);
    rq.delete();
    wq.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    reset = 1'b0;

    // Word round trip
    expw(32'h100, 32'hDEADBEEF);
    req(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2);
    req(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2);

    // Byte store, signed/unsigned byte loads
    expw(32'h200, 32'h11223344);
    req(1, 3'b010, 32'h200, 32'h11223344, 32'h0, 0, 2);
    expw(32'h200, 32'h11AB3344);
    req(1, 3'b000, 32'h202, 32'hFFFFFFAB, 32'h0, 0, 3);
    req(0, 3'b000, 32'h202, 32'h0, 32'hFFFFFFAB, 0, 2);
    req(0, 3'b100, 32'h202, 32'h0, 32'h000000AB, 0, 2);
    req(0, 3'b010, 32'h200, 32'h0, 32'h11AB3344, 0, 2);

    // Split halfword store and loads
    expw(32'h300, 32'hAABBCCDD);
    req(1, 3'b010, 32'h300, 32'hAABBCCDD, 32'h0, 0, 2);
    expw(32'h304, 32'h11223344);
    req(1, 3'b010, 32'h304, 32'h11223344, 32'h0, 0, 2);
    expw(32'h300, 32'h65BBCCDD);
    expw(32'h304, 32'h11223387);
    req(1, 3'b001, 32'h303, 32'h12348765, 32'h0, 0, 5);
    req(0, 3'b001, 32'h303, 32'h0, 32'hFFFF8765, 0, 3);
    req(0, 3'b101, 32'h303, 32'h0, 32'h00008765, 0, 3);
    req(0, 3'b001, 32'h301, 32'h0, 32'hFFFFBBCC, 0, 2);

    // Errors: no memory write, rdata forced to 0
    req(0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 1);
    req(0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1);
    req(1, 3'b110, 32'h100, 32'h12345678, 32'h0, 1, 1);
    req(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2);

    // Address wrap on split halfword
    expw(32'hFFFFFFFC, 32'h01020304);
    req(1, 3'b010, 32'hFFFFFFFC, 32'h01020304, 32'h0, 0, 2);
    expw(32'h0, 32'hA0B0C0D0);
    req(1, 3'b010, 32'h0, 32'hA0B0C0D0, 32'h0, 0, 2);
    expw(32'hFFFFFFFC, 32'hEF020304);
    expw(32'h0, 32'hA0B0C0BE);
    req(1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, 32'h0, 0, 5);

    // Reset while in WR1 of a split SH: word0 written, word1 untouched
    expw(32'h300, 32'h55BBCCDD);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h303; req_wdata = 32'h00005555;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_resp_valid2", 32'(resp_valid), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_word0_written", 32'(wq.size()), 32'd0);
    wq.delete();
    req(0, 3'b010, 32'h304, 32'h0, 32'h11223387, 0, 2);
    req(0, 3'b010, 32'h300, 32'h0, 32'h55BBCCDD, 0, 2);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
